max_pool_2x2: RTL and testbench

//  Downstream consumer of the 4-channel FP32 sum/ReLU stage. Takes its raster-order stream of
//  non-negative FP32 pixels (one per valid cycle, input_x wide, input_y tall) and emits 2x2
//  max-pooled pixels (stride 2) in raster order, with frame start/end markers, to the next layer.

---
 rtl/max_pool_2x2.sv | 107 ++++++++++
 tb/tb_max_pool_2x2.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-order stream of non-negative FP32 pixels.
// Horizontal pairs are reduced in a hold register, and vertical pairs through a half-width line buffer.
module max_pool_2x2 #(
    parameter int input_x = 4,
    parameter int input_y = input_x
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_valid,
    input  logic [31:0] data_in,
    input  logic        i_sof,
    output logic        output_valid,
    output logic [31:0] data_out,
    output logic        o_sof,
    output logic        o_eof
);

    localparam int Half = input_x / 2;
    localparam int ColW = (input_x > 1) ? $clog2(input_x) : 1;
    localparam int RowW = (input_y > 1) ? $clog2(input_y) : 1;
    localparam int IdxW = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(input_x - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(input_y - 1);

    if ((input_x % 2) != 0 || (input_y % 2) != 0 || input_x < 2 || input_y < 2) begin : g_bad_dims
        $error("max_pool_2x2: input_x and input_y must be even and >= 2");
    end

    logic [ColW-1:0] r_col;
    logic [RowW-1:0] r_row;
    logic [31:0]     r_hold;
    logic [31:0]     r_line_buf [Half];

    logic [ColW-1:0] w_col;
    logic [ColW-1:0] w_col_next;
    logic [RowW-1:0] w_row;
    logic [RowW-1:0] w_row_next;
    logic [IdxW-1:0] w_idx;
    logic [31:0]     w_pix;
    logic [31:0]     w_hmax;
    logic [31:0]     w_lb_rd;
    logic [31:0]     w_vmax;
    logic            w_col_odd;
    logic            w_row_odd;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_first_out;

    always_comb begin
        // i_sof forces this pixel to (0,0) and abandons any partial frame
        w_col      = i_sof ? '0 : r_col;
        w_row      = i_sof ? '0 : r_row;
        w_col_odd  = w_col[0];
        w_row_odd  = w_row[0];
        w_col_last = (w_col == ColLast);
        w_row_last = (w_row == RowLast);
        w_col_next = w_col_last ? '0 : w_col + 1'b1;
        w_row_next = w_row;
        if (w_col_last) begin
            w_row_next = w_row_last ? '0 : w_row + 1'b1;
        end
        w_first_out = (w_row == RowW'(1)) && (w_col == ColW'(1));

        // Negative inputs count as +0; magnitude compare, earlier pixel wins ties
        w_pix   = data_in[31] ? 32'h0000_0000 : data_in;
        w_hmax  = (w_pix[30:0] > r_hold[30:0]) ? w_pix : r_hold;
        w_idx   = IdxW'(w_col >> 1);
        w_lb_rd = r_line_buf[w_idx];
        w_vmax  = (w_hmax[30:0] > w_lb_rd[30:0]) ? w_hmax : w_lb_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= 32'h0000_0000;
            output_valid <= 1'b0;
            data_out     <= 32'h0000_0000;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            if (input_valid) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
                if (!w_col_odd) begin
                    r_hold <= w_pix;
                end else if (w_row_odd) begin
                    data_out     <= w_vmax;
                    output_valid <= 1'b1;
                    o_sof        <= w_first_out;
                    o_eof        <= w_row_last && w_col_last;
                end
            end
        end
    end

    // Every entry is written on an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (input_valid && w_col_odd && !w_row_odd) begin
            r_line_buf[w_idx] <= w_hmax;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: 4x4 instance driven from a vector table, 2x2 instance by hand.
module tb_max_pool_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_valid, i_sof;
    logic [31:0] data_in;
    logic        output_valid, o_sof, o_eof;
    logic [31:0] data_out;
    logic        input_valid_b, i_sof_b;
    logic [31:0] data_in_b;
    logic        output_valid_b, o_sof_b, o_eof_b;
    logic [31:0] data_out_b;

    always #5 clk = ~clk;

    max_pool_2x2 #(.input_x(4), .input_y(4)) u_dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .data_in(data_in), .i_sof(i_sof),
        .output_valid(output_valid), .data_out(data_out), .o_sof(o_sof), .o_eof(o_eof)
    );

    max_pool_2x2 #(.input_x(2), .input_y(2)) u_dut_b (
        .clk(clk), .rst(rst), .input_valid(input_valid_b), .data_in(data_in_b), .i_sof(i_sof_b),
        .output_valid(output_valid_b), .data_out(data_out_b), .o_sof(o_sof_b), .o_eof(o_eof_b)
    );

    typedef struct {
        logic        sof;
        logic [31:0] data;
        logic        ev;
        logic [31:0] ed;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t        tbl[16];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_hold   = 32'h0;
    logic [31:0] exp_hold_b = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic apply(input string tag, input vec_t v, input logic sof);
        input_valid = 1'b1;
        i_sof       = sof;
        data_in     = v.data;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        i_sof       = 1'b0;
        if (v.ev) exp_hold = v.ed;
        check({tag, " valid"}, 32'(output_valid), 32'(v.ev));
        check({tag, " data"}, data_out, exp_hold);
        check({tag, " sof"}, 32'(o_sof), 32'(v.ev & v.es));
        check({tag, " eof"}, 32'(o_eof), 32'(v.ev & v.ee));
    endtask

    task automatic idle(input string tag, input logic sof_noise);
        input_valid = 1'b0;
        i_sof       = sof_noise;
        data_in     = $urandom;
        @(posedge clk);
        #1;
        i_sof = 1'b0;
        check({tag, " idle valid"}, 32'(output_valid), 32'h0);
        check({tag, " idle data"}, data_out, exp_hold);
    endtask

    task automatic apply_b(input string tag, input logic sof, input logic [31:0] d,
                           input logic ev, input logic [31:0] ed);
        input_valid_b = 1'b1;
        i_sof_b       = sof;
        data_in_b     = d;
        @(posedge clk);
        #1;
        input_valid_b = 1'b0;
        i_sof_b       = 1'b0;
        if (ev) exp_hold_b = ed;
        check({tag, " valid"}, 32'(output_valid_b), 32'(ev));
        check({tag, " data"}, data_out_b, exp_hold_b);
        check({tag, " sof"}, 32'(o_sof_b), 32'(ev));
        check({tag, " eof"}, 32'(o_eof_b), 32'(ev));
    endtask

    initial begin
        logic [31:0] fv[16];
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
               32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
               32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        for (int k = 0; k < 16; k++) begin
            tbl[k] = '{sof: (k == 0), data: fv[k], ev: 1'b0, ed: 32'h0, es: 1'b0, ee: 1'b0};
        end
        tbl[5]  = '{sof: 1'b0, data: fv[5],  ev: 1'b1, ed: 32'h40C00000, es: 1'b1, ee: 1'b0};
        tbl[7]  = '{sof: 1'b0, data: fv[7],  ev: 1'b1, ed: 32'h41000000, es: 1'b0, ee: 1'b0};
        tbl[13] = '{sof: 1'b0, data: fv[13], ev: 1'b1, ed: 32'h41600000, es: 1'b0, ee: 1'b0};
        tbl[15] = '{sof: 1'b0, data: fv[15], ev: 1'b1, ed: 32'h41800000, es: 1'b0, ee: 1'b1};

        rst = 1'b1;
        input_valid = 1'b0; i_sof = 1'b0; data_in = 32'h0;
        input_valid_b = 1'b0; i_sof_b = 1'b0; data_in_b = 32'h0;
        #2 rst = 1'b0;
        #2;
        check("reset valid", 32'(output_valid), 32'h0);
        check("reset data", data_out, 32'h0);
        check("reset sof", 32'(o_sof), 32'h0);
        check("reset eof", 32'(o_eof), 32'h0);
        #4 rst = 1'b1;

        // 1) continuous 4x4 frame
        for (int k = 0; k < 16; k++) apply($sformatf("t1 px%0d", k + 1), tbl[k], tbl[k].sof);

        // 2) random stalls, with stray i_sof while invalid
        for (int k = 0; k < 16; k++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) idle($sformatf("t2 px%0d", k + 1), 1'($urandom_range(0, 1)));
            apply($sformatf("t2 px%0d", k + 1), tbl[k], tbl[k].sof);
        end

        // 3) 2x2 instance: negative handling, ties, both markers on one output
        apply_b("t3a p0", 1'b1, 32'hBF800000, 1'b0, 32'h0);
        apply_b("t3a p1", 1'b0, 32'h00000000, 1'b0, 32'h0);
        apply_b("t3a p2", 1'b0, 32'h80000000, 1'b0, 32'h0);
        apply_b("t3a p3", 1'b0, 32'h00000000, 1'b1, 32'h00000000);
        apply_b("t3b p0", 1'b1, 32'h40000000, 1'b0, 32'h0);
        apply_b("t3b p1", 1'b0, 32'h40000000, 1'b0, 32'h0);
        apply_b("t3b p2", 1'b0, 32'h40000000, 1'b0, 32'h0);
        apply_b("t3b p3", 1'b0, 32'h40000000, 1'b1, 32'h40000000);
        apply_b("t3c p0", 1'b0, 32'hFF800000, 1'b0, 32'h0);
        apply_b("t3c p1", 1'b0, 32'h00000001, 1'b0, 32'h0);
        apply_b("t3c p2", 1'b0, 32'h80000000, 1'b0, 32'h0);
        apply_b("t3c p3", 1'b0, 32'h00000000, 1'b1, 32'h00000001);
        apply_b("t3d p0", 1'b1, 32'h3F800000, 1'b0, 32'h0);
        apply_b("t3d p1", 1'b0, 32'h40400000, 1'b0, 32'h0);
        apply_b("t3d p2", 1'b0, 32'h40000000, 1'b0, 32'h0);
        apply_b("t3d p3", 1'b0, 32'h3F800000, 1'b1, 32'h40400000);
        apply_b("t3e p0", 1'b1, 32'h3F800000, 1'b0, 32'h0);
        apply_b("t3e p1", 1'b0, 32'h40000000, 1'b0, 32'h0);
        apply_b("t3e p2", 1'b0, 32'h40800000, 1'b0, 32'h0);
        apply_b("t3e p3", 1'b0, 32'h40400000, 1'b1, 32'h40800000);

        // 4) abort after 7 pixels, restart with i_sof
        for (int k = 0; k < 7; k++) apply($sformatf("t4 abort px%0d", k + 1), tbl[k], tbl[k].sof);
        for (int k = 0; k < 16; k++) apply($sformatf("t4 px%0d", k + 1), tbl[k], tbl[k].sof);

        // 5) async reset after pixel 10, then two frames without i_sof
        for (int k = 0; k < 10; k++) apply($sformatf("t5 pre px%0d", k + 1), tbl[k], tbl[k].sof);
        rst = 1'b0;
        #2;
        check("t5 async valid", 32'(output_valid), 32'h0);
        check("t5 async data", data_out, 32'h0);
        check("t5 async sof", 32'(o_sof), 32'h0);
        check("t5 async eof", 32'(o_eof), 32'h0);
        exp_hold   = 32'h0;
        exp_hold_b = 32'h0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) apply($sformatf("t5 f%0d px%0d", f, k + 1), tbl[k], 1'b0);
        end

        // 6) back-to-back frames with i_sof
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) apply($sformatf("t6 f%0d px%0d", f, k + 1), tbl[k], tbl[k].sof);
        end
        idle("t6 tail", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
